clk_en_gen: RTL and testbench

- Parametrised clock-enable and divided-clock generator that sits directly behind the PLL/clock-wizard output in the fabric clock domain.
- Releases a clean reset only once the PLL lock has been stable for a programmable time.
- Produces N_CH independently programmable clock-enable pulses and square-wave divided clocks.
- Divisors are runtime-reloadable through a write/ack handshake, with glitch-free reload at period boundaries.

---
 rtl/clk_en_gen.sv | 132 +++++++++++++
 tb/tb_clk_en_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// Clock-enable / divided-clock generator behind the PLL output: holds downstream
// reset until lock has been stable, then runs N_CH reloadable divider channels.
module clk_en_gen #(
  parameter int N_CH     = 4,
  parameter int DIV_W    = 16,
  parameter int LOCK_CYC = 256,
  parameter int DEF_DIV  = 50,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             div_wr,
  input  logic [CH_W-1:0]  div_ch,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  input  logic             sync_all,
  output logic             rst_out,
  output logic             ready,
  output logic [N_CH-1:0]  ce,
  output logic [N_CH-1:0]  clk_div
);

  localparam int LC_W = $clog2(LOCK_CYC);
  localparam logic [LC_W-1:0]  LC_LAST = LC_W'(LOCK_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);

  // state       | meaning
  // S_WAIT_LOCK | PLL not (yet) locked, lock counter held at 0
  // S_COUNT     | lock seen, counting stable cycles before release
  // S_RUN       | reset released, channels running
  typedef enum logic [1:0] {S_WAIT_LOCK, S_COUNT, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2;
  logic [LC_W-1:0]  r_lock_cnt;
  logic             r_rst_out, r_ack, r_sync_q;
  logic [DIV_W-1:0] r_cnt [N_CH];
  logic [DIV_W-1:0] r_div [N_CH];
  logic [DIV_W-1:0] r_shadow [N_CH];
  logic [DIV_W-1:0] w_d [N_CH];
  logic [N_CH-1:0]  r_pend, r_clk_div, w_hit, w_wrap, w_ce;
  logic             w_run, w_stay;

  assign w_run  = (r_state == S_RUN);
  assign w_stay = w_run && (w_state_nxt == S_RUN);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_LOCK: if (r_sync2) w_state_nxt = S_COUNT;
      S_COUNT: begin
        if (!r_sync2)                  w_state_nxt = S_WAIT_LOCK;
        else if (r_lock_cnt == LC_LAST) w_state_nxt = S_RUN;
      end
      S_RUN:       if (!r_sync2) w_state_nxt = S_WAIT_LOCK;
      default:     w_state_nxt = S_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_state    <= S_WAIT_LOCK;
      r_lock_cnt <= '0;
      r_rst_out  <= 1'b1;
      r_ack      <= 1'b0;
    end else begin
      r_sync1    <= locked;
      r_sync2    <= r_sync1;
      r_state    <= w_state_nxt;
      r_lock_cnt <= (r_state == S_COUNT && w_state_nxt == S_COUNT) ?
                    r_lock_cnt + LC_W'(1) : '0;
      r_rst_out  <= (w_state_nxt != S_RUN);
      r_ack      <= div_wr;
    end
  end

  // Divisor 0 behaves as 1; r_sync_q blanks ce for the cycle right after sync_all.
  always_comb begin
    w_wrap = '0;
    w_ce   = '0;
    w_hit  = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_d[i]    = (r_div[i] == '0) ? DIV_W'(1) : r_div[i];
      w_wrap[i] = (r_cnt[i] == w_d[i] - DIV_W'(1));
      w_ce[i]   = w_wrap[i] && w_run && !r_sync_q;
      w_hit[i]  = div_wr && (div_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_q  <= 1'b0;
      r_pend    <= '0;
      r_clk_div <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i]    <= '0;
        r_div[i]    <= DIV_RST;
        r_shadow[i] <= DIV_RST;
      end
    end else begin
      r_sync_q <= w_stay && sync_all;
      for (int i = 0; i < N_CH; i++) begin
        if (w_hit[i]) r_shadow[i] <= div_val;
        // Active divisor only changes at a period boundary while running.
        if (!w_run || sync_all || w_ce[i]) begin
          if (w_hit[i])       r_div[i] <= div_val;
          else if (r_pend[i]) r_div[i] <= r_shadow[i];
          r_pend[i] <= 1'b0;
        end else if (w_hit[i]) begin
          r_pend[i] <= 1'b1;
        end
        if (!w_stay || sync_all) begin
          r_cnt[i]     <= '0;
          r_clk_div[i] <= 1'b0;
        end else begin
          r_cnt[i] <= w_wrap[i] ? '0 : r_cnt[i] + DIV_W'(1);
          if (w_ce[i]) r_clk_div[i] <= ~r_clk_div[i];
        end
      end
    end
  end

  assign ce      = w_ce;
  assign clk_div = r_clk_div;
  assign rst_out = r_rst_out;
  assign ready   = ~r_rst_out;
  assign div_ack = r_ack;

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen: timestamp-based reference model checked every cycle,
// plus hand-computed expectations at key cycles of a directed scenario.
module tb_clk_en_gen;
  localparam int N  = 5;
  localparam int DW = 16;
  localparam int LC = 16;
  localparam int DD = 50;
  localparam int R  = 23;   // edge that enters RUN after the first clean lock

  logic          clk, rst, locked, div_wr, sync_all;
  logic [2:0]    div_ch;
  logic [DW-1:0] div_val;
  logic          div_ack, rst_out, ready;
  logic [N-1:0]  ce, clk_div;

  clk_en_gen #(.N_CH(N), .DIV_W(DW), .LOCK_CYC(LC), .DEF_DIV(DD)) dut (
    .clk(clk), .rst(rst), .locked(locked), .div_wr(div_wr), .div_ch(div_ch),
    .div_val(div_val), .div_ack(div_ack), .sync_all(sync_all),
    .rst_out(rst_out), .ready(ready), .ce(ce), .clk_div(clk_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, want);
    end
  endtask

  // Reference model: lock release = an unbroken run of LC+1 synchronised-lock
  // samples; each channel tracks the cycle its current period started.
  bit m_valid = 0;
  bit m_h1, m_h2, m_run, m_mask, m_ack;
  int m_streak;
  int m_div [N];
  int m_sh [N];
  bit m_pend [N];
  int m_start [N];
  bit m_lvl [N];

  function automatic int per(input int i);
    return (m_div[i] == 0) ? 1 : m_div[i];
  endfunction

  function automatic bit exp_ce(input int i);
    return m_run && !m_mask && ((cyc - m_start[i]) == per(i) - 1);
  endfunction

  always @(posedge clk) begin
    bit ce_now [N];
    bit wrap_now [N];
    bit ls, was_run, stay, hit;
    for (int i = 0; i < N; i++) begin
      ce_now[i]   = exp_ce(i);
      wrap_now[i] = m_run && ((cyc - m_start[i]) == per(i) - 1);
    end
    cyc++;
    if (rst) begin
      m_valid = 1; m_h1 = 0; m_h2 = 0; m_streak = 0;
      m_run = 0; m_mask = 0; m_ack = 0;
      for (int i = 0; i < N; i++) begin
        m_div[i] = DD; m_sh[i] = DD; m_pend[i] = 0; m_start[i] = cyc; m_lvl[i] = 0;
      end
    end else begin
      ls = m_h2; m_h2 = m_h1; m_h1 = locked;
      was_run  = m_run;
      m_streak = ls ? m_streak + 1 : 0;
      m_run    = ls && (was_run || m_streak > LC);
      stay     = was_run && m_run;
      for (int i = 0; i < N; i++) begin
        hit = div_wr && (int'(div_ch) == i);
        if (!was_run || sync_all || ce_now[i]) begin
          if (hit)            m_div[i] = int'(div_val);
          else if (m_pend[i]) m_div[i] = m_sh[i];
          m_pend[i] = 0;
        end else if (hit) begin
          m_pend[i] = 1;
        end
        if (hit) m_sh[i] = int'(div_val);
        if (!stay || sync_all) begin
          m_start[i] = cyc; m_lvl[i] = 0;
        end else if (wrap_now[i]) begin
          m_start[i] = cyc;
          if (ce_now[i]) m_lvl[i] = !m_lvl[i];
        end
      end
      m_mask = stay && sync_all;
      m_ack  = div_wr;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] e_ce, e_cd;
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        e_ce[i] = exp_ce(i);
        e_cd[i] = m_lvl[i];
      end
      chk("model_rst_out", 32'(rst_out), 32'(!m_run));
      chk("model_ready",   32'(ready),   32'(m_run));
      chk("model_ce",      32'(ce),      32'(e_ce));
      chk("model_clk_div", 32'(clk_div), 32'(e_cd));
      chk("model_div_ack", 32'(div_ack), 32'(m_ack));
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wr(input int n, input logic [2:0] ch, input logic [DW-1:0] v);
    wait_cyc(n);
    div_wr = 1'b1; div_ch = ch; div_val = v;
  endtask

  initial begin
    rst = 1'b1; locked = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0; sync_all = 1'b0;
    wait_cyc(4);
    chk("rst_rst_out", 32'(rst_out), 32'd1);
    chk("rst_ready",   32'(ready),   32'd0);
    chk("rst_ce",      32'(ce),      32'd0);
    chk("rst_clk_div", 32'(clk_div), 32'd0);
    chk("rst_ack",     32'(div_ack), 32'd0);
    rst = 1'b0; locked = 1'b1;
    wait_cyc(R - 1); chk("lock_hold", 32'(rst_out), 32'd1);
    wait_cyc(R);     chk("lock_release", 32'(rst_out), 32'd0);
                     chk("lock_ready", 32'(ready), 32'd1);
    // ch1 -> 3 mid-period: old period completes first
    wr(R + 20, 3'd1, 16'd3);
    wait_cyc(R + 21); div_wr = 1'b0; chk("ack_pulse", 32'(div_ack), 32'd1);
    wait_cyc(R + 22); chk("ack_end", 32'(div_ack), 32'd0);
    wait_cyc(R + 48); chk("ce0_r48", 32'(ce[0]), 32'd0);
    wait_cyc(R + 49); chk("ce0_r49", 32'(ce[0]), 32'd1);
                      chk("ce1_r49", 32'(ce[1]), 32'd1);
                      chk("cd0_r49", 32'(clk_div[0]), 32'd0);
    wait_cyc(R + 50); chk("cd0_r50", 32'(clk_div[0]), 32'd1);
                      chk("ce1_r50", 32'(ce[1]), 32'd0);
    wait_cyc(R + 52); chk("ce1_r52", 32'(ce[1]), 32'd1);
                      chk("ce0_r52", 32'(ce[0]), 32'd0);
    wait_cyc(R + 55); chk("ce1_r55", 32'(ce[1]), 32'd1);
    wait_cyc(R + 58); chk("ce1_r58", 32'(ce[1]), 32'd1);
    // divisor 0 and 1, then an out-of-range channel
    wr(R + 60, 3'd2, 16'd0);
    wr(R + 61, 3'd3, 16'd1);
    wr(R + 62, 3'd7, 16'd9);
    wait_cyc(R + 63); div_wr = 1'b0; chk("ack_ch7", 32'(div_ack), 32'd1);
    wait_cyc(R + 99);  chk("ce0_r99", 32'(ce[0]), 32'd1);
                       chk("cd0_r99", 32'(clk_div[0]), 32'd1);
                       chk("ce4_r99", 32'(ce[4]), 32'd1);
    wait_cyc(R + 100); chk("cd0_r100", 32'(clk_div[0]), 32'd0);
                       chk("ce2_r100", 32'(ce[2]), 32'd1);
                       chk("ce3_r100", 32'(ce[3]), 32'd1);
                       chk("cd2_r100", 32'(clk_div[2]), 32'd0);
    wait_cyc(R + 101); chk("ce2_r101", 32'(ce[2]), 32'd1);
                       chk("cd2_r101", 32'(clk_div[2]), 32'd1);
    wait_cyc(R + 102); chk("cd2_r102", 32'(clk_div[2]), 32'd0);
    // ch0 -> 4, ch1 -> 6 written in ch1's wrap cycle
    wr(R + 105, 3'd0, 16'd4);
    wr(R + 106, 3'd1, 16'd6);
    chk("ce1_r106", 32'(ce[1]), 32'd1);
    wait_cyc(R + 107); div_wr = 1'b0;
    wait_cyc(R + 109); chk("ce1_r109", 32'(ce[1]), 32'd0);
    wait_cyc(R + 112); chk("ce1_r112", 32'(ce[1]), 32'd1);
    wait_cyc(R + 149); chk("ce0_r149", 32'(ce[0]), 32'd1);
    wait_cyc(R + 153); chk("ce0_r153", 32'(ce[0]), 32'd1);
    wait_cyc(R + 160); sync_all = 1'b1;
    wait_cyc(R + 161); sync_all = 1'b0;
                       chk("sync_cd0", 32'(clk_div[0]), 32'd0);
                       chk("sync_cd1", 32'(clk_div[1]), 32'd0);
                       chk("sync_ce0", 32'(ce[0]), 32'd0);
    wait_cyc(R + 164); chk("sync_ce0_p4", 32'(ce[0]), 32'd1);
    wait_cyc(R + 166); chk("sync_ce1_p6", 32'(ce[1]), 32'd1);
                       chk("sync_ce0_r166", 32'(ce[0]), 32'd0);
    // lock drop in RUN
    wait_cyc(R + 180); locked = 1'b0;
    wait_cyc(R + 181); locked = 1'b1;
    wait_cyc(R + 182); chk("drop_r182", 32'(rst_out), 32'd0);
    wait_cyc(R + 183); chk("drop_r183", 32'(rst_out), 32'd1);
                       chk("drop_ce", 32'(ce), 32'd0);
                       chk("drop_cd", 32'(clk_div), 32'd0);
    // glitch while counting (lock_cnt = 10 when seen)
    wait_cyc(R + 192); locked = 1'b0;
    wait_cyc(R + 193); locked = 1'b1;
    wait_cyc(R + 200); chk("glitch_r200", 32'(rst_out), 32'd1);
    wait_cyc(R + 211); chk("glitch_r211", 32'(rst_out), 32'd1);
    wait_cyc(R + 212); chk("glitch_r212", 32'(rst_out), 32'd0);
    wait_cyc(R + 215); chk("rerun_ce0", 32'(ce[0]), 32'd1);
    // reset asserted mid-COUNT restores default divisors
    wait_cyc(R + 230); locked = 1'b0;
    wait_cyc(R + 231); locked = 1'b1;
    wait_cyc(R + 240); rst = 1'b1;
    wait_cyc(R + 242); rst = 1'b0;
                       chk("midrst_rst_out", 32'(rst_out), 32'd1);
    wait_cyc(R + 260); chk("midrst_r260", 32'(rst_out), 32'd1);
    wait_cyc(R + 261); chk("midrst_r261", 32'(rst_out), 32'd0);
    wait_cyc(R + 266); chk("midrst_ce1_r266", 32'(ce[1]), 32'd0);
    wait_cyc(R + 310); chk("midrst_ce0_r310", 32'(ce[0]), 32'd1);
                       chk("midrst_ce1_r310", 32'(ce[1]), 32'd1);
    wait_cyc(R + 320);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout at cycle %0d, want finish", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
